// File: rtl/tile_sequencer.sv
// Purpose: frame-level tile controller; per tile clears the buffer, fetches the splat range, rasterizes each splat, flushes.
// Latency: 1024 clear cycles + 2 range + 3 per splat + 3 flush/advance cycles per tile, excluding external waits.
// Backpressure: waits indefinitely on rng_valid/sp_ready/rast_done/flush_done; strobes outside their wait state are ignored.
module tile_sequencer #(
   parameter int TILES_X = 20,
   parameter int TILES_Y = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_start,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] tile_px,
   output logic [15:0] tile_py,
   output logic        rng_req,
   output logic [15:0] rng_tile,
   input  logic        rng_valid,
   input  logic [19:0] rng_first,
   input  logic [15:0] rng_count,
   output logic        sp_req,
   output logic [19:0] sp_idx,
   input  logic        sp_ready,
   output logic        rast_start,
   input  logic        rast_done,
   output logic [9:0]  clr_addr,
   output logic        clr_wr_en,
   output logic [1:0]  tb_owner,
   output logic        flush_start,
   input  logic        flush_done
);

   // Tile buffer owner encodings seen by the port mux.
   localparam logic [1:0] OWN_RAST  = 2'd0;
   localparam logic [1:0] OWN_CLEAR = 2'd1;
   localparam logic [1:0] OWN_FLUSH = 2'd2;

   // Tile coordinates are 11 bits so that {tile,5'b0} fills exactly 16 bits.
   localparam logic [10:0] LAST_X = 11'(TILES_X - 1);
   localparam logic [10:0] LAST_Y = 11'(TILES_Y - 1);

   typedef enum logic [3:0] {
      IDLE,
      CLEAR,
      RNG_REQ,
      RNG_WAIT,
      SP_REQ,
      SP_WAIT,
      RAST,
      FLUSH,
      FLUSH_WAIT,
      NEXT,
      DONE
   } state_t;

   // Splat range response as one bundle.
   typedef struct packed {
      logic [19:0] first;
      logic [15:0] count;
   } rng_rsp_t;

   state_t      state;
   state_t      state_nxt;
   rng_rsp_t    rsp;
   logic [10:0] tile_x;
   logic [10:0] tile_y;
   logic [15:0] remaining;
   logic        last_tile;
   logic        clear_last;
   logic        last_splat;

   assign rsp        = '{first: rng_first, count: rng_count};
   assign last_tile  = (tile_x == LAST_X) && (tile_y == LAST_Y);
   assign clear_last = (clr_addr == 10'd1023);
   assign last_splat = (remaining == 16'd1);

   // Origin and linear index come straight from the tile registers, so they only move in NEXT.
   assign tile_px  = {tile_x, 5'b0};
   assign tile_py  = {tile_y, 5'b0};
   assign rng_tile = 16'(32'(tile_y) * 32'(TILES_X) + 32'(tile_x));

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and the state-derived strobes / mux select.
   always_comb begin
      state_nxt   = state;
      busy        = 1'b1;
      frame_done  = 1'b0;
      rng_req     = 1'b0;
      sp_req      = 1'b0;
      clr_wr_en   = 1'b0;
      flush_start = 1'b0;
      tb_owner    = OWN_RAST;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (frame_start) begin
               state_nxt = CLEAR;
            end
         end
         CLEAR: begin
            tb_owner  = OWN_CLEAR;
            clr_wr_en = 1'b1;
            if (clear_last) begin
               state_nxt = RNG_REQ;
            end
         end
         RNG_REQ: begin
            rng_req   = 1'b1;
            state_nxt = RNG_WAIT;
         end
         RNG_WAIT: begin
            if (rng_valid) begin
               state_nxt = (rsp.count == 16'd0) ? FLUSH : SP_REQ;
            end
         end
         SP_REQ: begin
            sp_req    = 1'b1;
            state_nxt = SP_WAIT;
         end
         SP_WAIT: begin
            if (sp_ready) begin
               state_nxt = RAST;
            end
         end
         RAST: begin
            if (rast_done) begin
               state_nxt = last_splat ? FLUSH : SP_REQ;
            end
         end
         FLUSH: begin
            tb_owner    = OWN_FLUSH;
            flush_start = 1'b1;
            state_nxt   = FLUSH_WAIT;
         end
         FLUSH_WAIT: begin
            tb_owner = OWN_FLUSH;
            if (flush_done) begin
               state_nxt = NEXT;
            end
         end
         NEXT: begin
            state_nxt = last_tile ? DONE : CLEAR;
         end
         DONE: begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // rast_start is registered so it stays a single-cycle pulse even though RAST lasts many cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         rast_start <= 1'b0;
      end else begin
         rast_start <= (state == SP_WAIT) && sp_ready;
      end
   end

   // Clear address walks 0..1023 and naturally wraps back to 0 for the next tile.
   always_ff @(posedge clk) begin
      if (reset) begin
         clr_addr <= 10'd0;
      end else if (state == IDLE && frame_start) begin
         clr_addr <= 10'd0;
      end else if (state == CLEAR) begin
         clr_addr <= clr_addr + 10'd1;
      end
   end

   // Splat cursor: loaded from the range response, advanced after each non-final rasterization.
   always_ff @(posedge clk) begin
      if (reset) begin
         sp_idx    <= 20'd0;
         remaining <= 16'd0;
      end else if (state == RNG_WAIT && rng_valid && rsp.count != 16'd0) begin
         sp_idx    <= rsp.first;
         remaining <= rsp.count;
      end else if (state == RAST && rast_done) begin
         remaining <= remaining - 16'd1;
         if (!last_splat) begin
            sp_idx <= sp_idx + 20'd1;
         end
      end
   end

   // Raster-order tile walk; the last tile wraps both coordinates back to the origin.
   always_ff @(posedge clk) begin
      if (reset) begin
         tile_x <= 11'd0;
         tile_y <= 11'd0;
      end else if (state == IDLE && frame_start) begin
         tile_x <= 11'd0;
         tile_y <= 11'd0;
      end else if (state == NEXT) begin
         if (last_tile) begin
            tile_x <= 11'd0;
            tile_y <= 11'd0;
         end else if (tile_x == LAST_X) begin
            tile_x <= 11'd0;
            tile_y <= tile_y + 11'd1;
         end else begin
            tile_x <= tile_x + 11'd1;
         end
      end
   end

endmodule

// File: tb/tb_tile_sequencer.sv
// Directed bench for tile_sequencer on a 2x2 tile grid: per-tile vector table plus clear-sweep and reset sequences.
// Inputs are driven and outputs sampled on the falling edge; the bench acts as range source, splat reader, rasterizer and flush writer.
module tb_tile_sequencer;

   logic        clk;
   logic        reset;
   logic        frame_start;
   logic        busy;
   logic        frame_done;
   logic [15:0] tile_px;
   logic [15:0] tile_py;
   logic        rng_req;
   logic [15:0] rng_tile;
   logic        rng_valid;
   logic [19:0] rng_first;
   logic [15:0] rng_count;
   logic        sp_req;
   logic [19:0] sp_idx;
   logic        sp_ready;
   logic        rast_start;
   logic        rast_done;
   logic [9:0]  clr_addr;
   logic        clr_wr_en;
   logic [1:0]  tb_owner;
   logic        flush_start;
   logic        flush_done;

   tile_sequencer #(.TILES_X(2), .TILES_Y(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .busy        (busy),
      .frame_done  (frame_done),
      .tile_px     (tile_px),
      .tile_py     (tile_py),
      .rng_req     (rng_req),
      .rng_tile    (rng_tile),
      .rng_valid   (rng_valid),
      .rng_first   (rng_first),
      .rng_count   (rng_count),
      .sp_req      (sp_req),
      .sp_idx      (sp_idx),
      .sp_ready    (sp_ready),
      .rast_start  (rast_start),
      .rast_done   (rast_done),
      .clr_addr    (clr_addr),
      .clr_wr_en   (clr_wr_en),
      .tb_owner    (tb_owner),
      .flush_start (flush_start),
      .flush_done  (flush_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] first;
      logic [15:0] count;
      int          sp_lat;
      bit          poke;
      logic [15:0] exp_tile;
      logic [15:0] exp_px;
      logic [15:0] exp_py;
   } vec_t;

   vec_t vecs[8];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_rast   = 0;
   int   n_flush  = 0;
   int   n_done   = 0;

   // Pulse counters for whole-frame totals.
   always @(negedge clk) begin
      if (rast_start === 1'b1) n_rast++;
      if (flush_start === 1'b1) n_flush++;
      if (frame_done === 1'b1) n_done++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_rng_req(input int budget, output int waited);
      waited = 0;
      while (rng_req !== 1'b1 && waited < budget) begin
         @(negedge clk);
         waited++;
      end
   endtask

   // Serves one tile starting anywhere before its rng_req; returns in the NEXT cycle.
   task automatic run_tile(input vec_t v, input int exp_wait);
      int          w;
      logic [19:0] exp_idx;
      wait_rng_req(1100, w);
      check("rng_req_seen", rng_req, 1);
      check("rng_req_latency", w, exp_wait);
      check("rng_tile", rng_tile, v.exp_tile);
      check("tile_px", tile_px, v.exp_px);
      check("tile_py", tile_py, v.exp_py);
      @(negedge clk);
      check("rng_req_width", rng_req, 0);
      rng_valid = 1'b1;
      rng_first = v.first;
      rng_count = v.count;
      @(negedge clk);
      rng_valid = 1'b0;
      if (v.count == 16'd0) begin
         check("empty_flush_start", flush_start, 1);
         check("empty_no_sp_req", sp_req, 0);
      end else begin
         for (int k = 0; k < int'(v.count); k++) begin
            exp_idx = 20'(32'(v.first) + k);
            check("sp_req", sp_req, 1);
            check("sp_idx_at_req", sp_idx, exp_idx);
            @(negedge clk);
            check("sp_req_width", sp_req, 0);
            check("owner_sp_wait", tb_owner, 0);
            repeat (v.sp_lat) @(negedge clk);
            sp_ready = 1'b1;
            @(negedge clk);
            sp_ready = 1'b0;
            check("rast_start_after_sp_ready", rast_start, 1);
            check("sp_idx_in_rast", sp_idx, exp_idx);
            if (v.poke && k == 0) begin
               frame_start = 1'b1;
               @(negedge clk);
               frame_start = 1'b0;
               check("busy_after_stray_frame_start", busy, 1);
               check("tile_px_after_stray_frame_start", tile_px, v.exp_px);
            end else begin
               @(negedge clk);
            end
            check("rast_start_width", rast_start, 0);
            rast_done = 1'b1;
            @(negedge clk);
            rast_done = 1'b0;
         end
         check("flush_start_after_last_rast", flush_start, 1);
      end
      check("owner_flush", tb_owner, 2);
      @(negedge clk);
      check("flush_start_width", flush_start, 0);
      check("owner_flush_wait", tb_owner, 2);
      repeat (2) @(negedge clk);
      flush_done = 1'b1;
      @(negedge clk);
      flush_done = 1'b0;
   endtask

   task automatic end_frame(input int base_rast, input int exp_rast, input int base_flush, input int base_done);
      check("frame_done_in_next", frame_done, 0);
      @(negedge clk);
      check("frame_done_pulse", frame_done, 1);
      check("busy_during_done", busy, 1);
      @(negedge clk);
      check("busy_after_done", busy, 0);
      check("frame_done_width", frame_done, 0);
      check("frame_rast_count", n_rast - base_rast, exp_rast);
      check("frame_flush_count", n_flush - base_flush, 4);
      check("frame_done_count", n_done - base_done, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      int   w;
      int   bad;
      int   b_rast;
      int   b_flush;
      int   b_done;
      vec_t v;

      vecs[0] = '{20'd100,     16'd1, 0, 1'b0, 16'd0, 16'd0,  16'd0};
      vecs[1] = '{20'd200,     16'd1, 1, 1'b0, 16'd1, 16'd32, 16'd0};
      vecs[2] = '{20'd300,     16'd1, 0, 1'b0, 16'd2, 16'd0,  16'd32};
      vecs[3] = '{20'd400,     16'd1, 2, 1'b0, 16'd3, 16'd32, 16'd32};
      vecs[4] = '{20'hFFFFE,   16'd3, 0, 1'b0, 16'd0, 16'd0,  16'd0};
      vecs[5] = '{20'd5,       16'd0, 0, 1'b0, 16'd1, 16'd32, 16'd0};
      vecs[6] = '{20'h12345,   16'd2, 1, 1'b1, 16'd2, 16'd0,  16'd32};
      vecs[7] = '{20'hFFFFF,   16'd1, 0, 1'b0, 16'd3, 16'd32, 16'd32};

      reset       = 1'b1;
      frame_start = 1'b0;
      rng_valid   = 1'b0;
      rng_first   = 20'd0;
      rng_count   = 16'd0;
      sp_ready    = 1'b0;
      rast_done   = 1'b0;
      flush_done  = 1'b0;
      repeat (3) @(negedge clk);

      check("reset_busy", busy, 0);
      check("reset_tb_owner", tb_owner, 0);
      check("reset_clr_wr_en", clr_wr_en, 0);
      check("reset_clr_addr", clr_addr, 0);
      check("reset_tile_px", tile_px, 0);
      check("reset_rng_tile", rng_tile, 0);
      check("reset_sp_idx", sp_idx, 0);
      check("reset_rast_start", rast_start, 0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_busy", busy, 0);

      // Frame A begins with the clear sweep; a stray rast_done lands mid-clear.
      b_rast  = n_rast;
      b_flush = n_flush;
      b_done  = n_done;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      check("busy_after_frame_start", busy, 1);
      bad = 0;
      for (int i = 0; i < 1024; i++) begin
         if (clr_addr !== 10'(i) || clr_wr_en !== 1'b1 || tb_owner !== 2'd1 || rng_req !== 1'b0)
            bad++;
         rast_done = (i == 500);
         @(negedge clk);
      end
      rast_done = 1'b0;
      check("clear_sweep_errors", bad, 0);
      check("clear_end_wr_en", clr_wr_en, 0);
      check("stray_rast_done_no_sp_req", sp_req, 0);

      for (int i = 0; i < 8; i++) begin
         if (i == 4) begin
            b_rast  = n_rast;
            b_flush = n_flush;
            b_done  = n_done;
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
            check("frame_b_busy", busy, 1);
         end
         run_tile(vecs[i], (i == 0) ? 0 : ((i == 4) ? 1024 : 1025));
         if (i == 3) end_frame(b_rast, 4, b_flush, b_done);
         if (i == 7) end_frame(b_rast, 6, b_flush, b_done);
      end

      // Frame C: empty first tile, then reset while rasterizing tile 1.
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      v = '{20'd9, 16'd0, 0, 1'b0, 16'd0, 16'd0, 16'd0};
      run_tile(v, 1024);
      wait_rng_req(1100, w);
      check("c_rng_req_latency", w, 1025);
      check("c_tile_px", tile_px, 32);
      @(negedge clk);
      rng_valid = 1'b1;
      rng_first = 20'd7;
      rng_count = 16'd2;
      @(negedge clk);
      rng_valid = 1'b0;
      @(negedge clk);
      sp_ready = 1'b1;
      @(negedge clk);
      sp_ready = 1'b0;
      check("c_rast_start", rast_start, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_busy", busy, 0);
      check("midreset_tb_owner", tb_owner, 0);
      check("midreset_tile_px", tile_px, 0);
      check("midreset_rng_tile", rng_tile, 0);
      check("midreset_sp_idx", sp_idx, 0);
      check("midreset_rast_start", rast_start, 0);
      check("midreset_clr_wr_en", clr_wr_en, 0);
      @(negedge clk);
      check("midreset_idle_busy", busy, 0);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      check("restart_busy", busy, 1);
      check("restart_clr_addr", clr_addr, 0);
      check("restart_clr_wr_en", clr_wr_en, 1);
      wait_rng_req(1100, w);
      check("restart_rng_req_latency", w, 1024);
      check("restart_rng_tile", rng_tile, 0);
      check("restart_tile_py", tile_py, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
